// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC and drives the instruction memory port.
// Fetched words are buffered in a 2-entry queue that decode drains over valid/ready.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES = 32'd32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    localparam logic [31:0] LAST_PC = MEM_BYTES - 32'd4;

    logic [31:0] pc;
    logic        halted;
    logic [1:0]  count;
    entry_t      head;
    entry_t      tail;

    logic        pop;
    logic        fetch_en;
    logic        fault;
    entry_t      fetched;

    assign imem_pc   = pc;
    assign out_valid = (count != 2'd0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_fault = head.fault;

    // Fetch only looks at the registered count, so a pop never frees a slot for the same cycle.
    always_comb begin
        pop           = out_valid && out_ready && !redirect_valid;
        fetch_en      = (count < 2'd2) && !halted && !redirect_valid;
        fault         = (pc[1:0] != 2'b00) || (pc > LAST_PC);
        fetched.pc    = pc;
        fetched.instr = fault ? NOP_INSTR : imem_instr;
        fetched.fault = fault;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            count  <= 2'd0;
            head   <= '0;
            tail   <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            halted <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (fetch_en) begin
                // A faulting fetch parks the PC and stops fetching until redirect or reset.
                if (fault) begin
                    halted <= 1'b1;
                end else begin
                    pc <= pc + 32'd4;
                end
            end
            case ({fetch_en, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= fetched;
                    end else begin
                        tail <= fetched;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                // Push and pop together only happen with one entry queued.
                2'b11: begin
                    head <= fetched;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a fixed vector table, directed corner sequences,
// and randomized traffic compared against a queue-based model of the fetch stage.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] MEM_BYTES = 32'd32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    logic [31:0] mem [8];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          fault;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mPc = '0;
    bit          mHalted = 1'b0;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          eValid;
        bit          chkHead;
        logic [31:0] ePc;
        logic [31:0] eInstr;
        bit          eFault;
        logic [31:0] eImem;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    // Out-of-range addresses return garbage so that NOP substitution is observable.
    always_comb begin
        imem_instr = 32'hBAD0_BAD0;
        if (imem_pc <= MEM_BYTES - 32'd4) imem_instr = mem[imem_pc[4:2]];
    end

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault)
    );

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " imem_pc"}, imem_pc, mPc);
        checkValue({tag, " out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            checkValue({tag, " out_pc"}, out_pc, q[0].pc);
            checkValue({tag, " out_instr"}, out_instr, q[0].instr);
            checkValue({tag, " out_fault"}, 32'(out_fault), 32'(q[0].fault));
        end
    endtask

    // Reference: a queue of fetched entries advanced one clock edge at a time.
    task automatic modelStep(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
        bit   canFetch;
        bit   flt;
        ent_t e;
        if (rst) begin
            q.delete();
            mPc     = '0;
            mHalted = 1'b0;
        end else if (redir) begin
            q.delete();
            mPc     = rpc;
            mHalted = 1'b0;
        end else begin
            canFetch = (q.size() < 2) && !mHalted;
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (canFetch) begin
                flt     = (mPc[1:0] != 2'b00) || (mPc > MEM_BYTES - 32'd4);
                e.pc    = mPc;
                e.instr = flt ? NOP : mem[mPc[4:2]];
                e.fault = flt;
                q.push_back(e);
                if (flt) mHalted = 1'b1;
                else mPc = mPc + 32'd4;
            end
        end
    endtask

    task automatic cycle(input string tag, input bit rst, input bit redir, input logic [31:0] rpc,
                         input bit rdy);
        applyStimulus(rst, redir, rpc, rdy);
        checkOutput(tag);
        modelStep(rst, redir, rpc, rdy);
    endtask

    function automatic vec_t mk(input bit rst, input bit valid, input bit chk, input logic [31:0] pc,
                                input logic [31:0] instr, input bit flt, input logic [31:0] imem);
        vec_t v;
        v.rst     = rst;
        v.rdy     = 1'b1;
        v.eValid  = valid;
        v.chkHead = chk;
        v.ePc     = pc;
        v.eInstr  = instr;
        v.eFault  = flt;
        v.eImem   = imem;
        return v;
    endfunction

    initial begin
        int unsigned sel;
        logic [31:0] tgt;

        mem[0] = 32'h33E2_6200;
        for (int i = 1; i < 8; i++) mem[i] = '0;

        vt.push_back(mk(1, 0, 1, 32'd0, 32'd0, 0, 32'd0));
        vt.push_back(mk(0, 0, 0, 32'd0, 32'd0, 0, 32'd0));
        vt.push_back(mk(0, 1, 1, 32'd0, 32'h33E2_6200, 0, 32'd4));
        for (int k = 3; k <= 9; k++) vt.push_back(mk(0, 1, 1, 32'(4 * (k - 2)), 32'd0, 0, 32'(4 * (k - 1))));
        vt.push_back(mk(0, 1, 1, 32'd32, NOP, 1, 32'd32));
        vt.push_back(mk(0, 0, 0, 32'd0, 32'd0, 0, 32'd32));
        vt.push_back(mk(0, 0, 0, 32'd0, 32'd0, 0, 32'd32));

        // First reset edge brings the DUT out of its unknown power-up state.
        applyStimulus(1, 0, '0, 1);
        modelStep(1, 0, '0, 1);

        foreach (vt[i]) begin
            string tag;
            tag = $sformatf("vec[%0d]", i);
            applyStimulus(vt[i].rst, 0, '0, vt[i].rdy);
            checkOutput({tag, " model"});
            checkValue({tag, " imem_pc"}, imem_pc, vt[i].eImem);
            checkValue({tag, " out_valid"}, 32'(out_valid), 32'(vt[i].eValid));
            if (vt[i].chkHead) begin
                checkValue({tag, " out_pc"}, out_pc, vt[i].ePc);
                checkValue({tag, " out_instr"}, out_instr, vt[i].eInstr);
                checkValue({tag, " out_fault"}, 32'(out_fault), 32'(vt[i].eFault));
            end
            modelStep(vt[i].rst, 0, '0, vt[i].rdy);
        end

        // Back-pressure: queue fills, PC stalls at 8, then drains in order.
        cycle("bp", 1, 0, '0, 0);
        cycle("bp", 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) cycle("bp", 0, 0, '0, 0);
        checkValue("bp imem_pc stall", imem_pc, 32'd8);
        checkValue("bp head held", out_pc, 32'd0);
        for (int i = 0; i < 6; i++) cycle("bp", 0, 0, '0, 1);

        // Redirect while full flushes both entries.
        cycle("flush", 1, 0, '0, 0);
        cycle("flush", 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle("flush", 0, 0, '0, 0);
        cycle("flush", 0, 1, 32'h10, 1);
        cycle("flush", 0, 0, '0, 1);
        checkValue("flush bubble valid", 32'(out_valid), 32'd0);
        cycle("flush", 0, 0, '0, 1);
        checkValue("flush first pc", out_pc, 32'h10);
        cycle("flush", 0, 0, '0, 1);
        checkValue("flush second pc", out_pc, 32'h14);

        // Misaligned redirect produces one fault entry and halts.
        cycle("misal", 0, 1, 32'h6, 1);
        cycle("misal", 0, 0, '0, 1);
        cycle("misal", 0, 0, '0, 1);
        checkValue("misal pc", out_pc, 32'h6);
        checkValue("misal fault", 32'(out_fault), 32'd1);
        checkValue("misal instr", out_instr, NOP);
        cycle("misal", 0, 0, '0, 1);
        cycle("misal", 0, 0, '0, 1);
        checkValue("misal halted pc", imem_pc, 32'h6);
        checkValue("misal no refetch", 32'(out_valid), 32'd0);
        cycle("misal", 0, 1, 32'h0, 1);
        for (int i = 0; i < 4; i++) cycle("misal", 0, 0, '0, 1);

        // Reset mid-stream with a full queue.
        for (int i = 0; i < 3; i++) cycle("rstmid", 0, 0, '0, 0);
        cycle("rstmid", 1, 0, '0, 1);
        cycle("rstmid", 0, 0, '0, 0);
        checkValue("rstmid valid", 32'(out_valid), 32'd0);
        checkValue("rstmid imem_pc", imem_pc, 32'd0);
        cycle("rstmid", 0, 0, '0, 1);
        checkValue("rstmid first pc", out_pc, 32'd0);
        for (int i = 0; i < 4; i++) cycle("rstmid", 0, 0, '0, (i % 2) == 0);

        // Randomized traffic with random memory contents.
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        cycle("rand", 1, 0, '0, 1);
        for (int n = 0; n < 800; n++) begin
            bit rst;
            bit redir;
            bit rdy;
            rst   = ($urandom_range(0, 63) == 0);
            redir = ($urandom_range(0, 11) == 0);
            rdy   = ($urandom_range(0, 9) < 7);
            sel   = $urandom_range(0, 3);
            case (sel)
                0:       tgt = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
                1:       tgt = 32'($urandom_range(0, 31));
                2:       tgt = 32'h40;
                default: tgt = $urandom;
            endcase
            cycle("rand", rst, redir, tgt, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage of the riscv32 core. Holds the program counter and drives the combinational instruction memory read port. Captures each fetched word into a 2-entry fetch queue and presents it to decode over a valid/ready handshake. Accepts PC redirects from execute (branch/jump), which flush queued fetches, and flags misaligned or out-of-range fetch addresses as faults.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MEM_BYTES, 32, size of instruction memory in bytes; a fetch at PC > MEM_BYTES-4 is out of range
- NOP_INSTR, 32'h0000_0013, instruction word substituted on a faulting fetch (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- imem_pc  out  32  fetch address to instruction memory; equals the internal pc register
- imem_instr  in  32  instruction word returned combinationally for imem_pc in the same cycle
- redirect_valid  in  1  load redirect_pc into pc and flush the queue
- redirect_pc  in  32  redirect target
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  32  PC of head entry
- out_instr  out  32  instruction of head entry
- out_fault  out  1  head entry is a faulting fetch

## Operation
- State: pc[31:0], halted, count[1:0] (0..2), two entries {pc, instr, fault}, FIFO order.
- imem_pc = pc at all times.
- out_valid = (count != 0); out_pc/out_instr/out_fault = head entry fields.
- pop = out_valid && out_ready && !redirect_valid.
- fetch_en = (count < 2) && !halted && !redirect_valid; uses registered count, so a pop does not free a slot for the same cycle's fetch.
- Fault condition: pc[1:0] != 0, or pc > MEM_BYTES-4 (unsigned 32-bit compare).
- On fetch_en: push {pc, fault ? NOP_INSTR : imem_instr, fault}. If no fault, pc <= pc + 4, with 32-bit wrap and carry dropped. If fault, pc holds and halted <= 1; no further fetches occur until a redirect or reset.
- Push and pop in the same cycle: count unchanged, head advances, new entry goes to the tail.
- On redirect_valid: count <= 0, halted <= 0, pc <= redirect_pc. No push or pop that cycle. The head shown that cycle is discarded and decode must not commit it.
- A misaligned or out-of-range redirect_pc is accepted. The next fetch produces a fault entry and halts.
- Reset has priority over redirect and fetch: pc <= RESET_PC, count <= 0, halted <= 0, both entries cleared to zero. Reset mid-stream discards all queued entries.

## Timing
- Reset values: imem_pc = RESET_PC, out_valid = 0, out_pc = 0, out_instr = 0, out_fault = 0.
- Reset-to-output: reset low in cycle C, fetch of RESET_PC in C, out_valid = 1 in C+1.
- Fetch-to-output latency: 1 cycle.
- Redirect latency: redirect in cycle N, out_valid = 0 in N+1 while redirect_pc is fetched, out_pc = redirect_pc valid in N+2.
- Throughput: with out_ready held high, 1 instruction per cycle in steady state (count stays at 1).
- With count = 2 and out_ready high: 1 cycle without a fetch, then steady state resumes.
- out_* must stay stable while out_valid && !out_ready, unless redirect or reset occurs.

## Test plan
- Bench memory: word0 = 0x33E26200, words 1-7 = 0. Reset 2 cycles, out_ready = 1 -> out_pc sequence 0,4,8,…,28, one per cycle; first out_instr = 0x33E26200. Then pc = 32 fetches as a fault: out_fault = 1, out_instr = 0x00000013, and fetching stops.
- out_ready = 0 for 5 cycles after reset -> count saturates at 2, imem_pc holds at 8, head stays out_pc = 0. Release out_ready -> out_pc 0,4,8 delivered in order, no drops and no duplicates.
- Redirect to 0x10 while count = 2 -> out_valid = 0 next cycle, then out_pc = 0x10, 0x14; the flushed entries 0 and 4 never reappear.
- Redirect to 0x6 (misaligned) -> one entry with out_pc = 6, out_fault = 1, out_instr = 0x00000013; imem_pc stays at 6. A subsequent redirect to 0 resumes normal fetch.
- Assert reset mid-stream with count = 2, out_ready toggling -> next cycle out_valid = 0 and imem_pc = RESET_PC; first post-reset out_pc = 0.
- Redirect_valid and out_ready both high with a valid head -> the head is not popped and the queue is flushed; redirect wins.
